// File: rtl/frame_overlap_buffer_if.sv
// frame_overlap_buffer_if: sample-in / frame-out stream bundle for frame_overlap_buffer
//   data_in/valid_in/ready_out : upstream sample handshake (ready_out driven by the buffer)
//   data_out/valid_out/last/ready_in : downstream frame handshake (ready_in driven by the sink)
//   frame_idx : index of the frame being emitted, or the next one
//   master: testbench / surrounding logic side; slave: the buffer itself
interface frame_overlap_buffer_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 16
);
    logic [DATA_W-1:0] data_in;
    logic              valid_in;
    logic              ready_out;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              last;
    logic              ready_in;
    logic [IDX_W-1:0]  frame_idx;
    modport master (
        output data_in, valid_in, ready_in,
        input  ready_out, data_out, valid_out, last, frame_idx
    );
    modport slave (
        input  data_in, valid_in, ready_in,
        output ready_out, data_out, valid_out, last, frame_idx
    );
endinterface

// File: rtl/frame_overlap_buffer.sv
// frame_overlap_buffer: cuts a sample stream into FRAME_LEN-word frames advancing by HOP samples
//   hclk  : clock, rising edge
//   rst_n : asynchronous active-low reset
//   flush : synchronous flush, discards all buffered state, wins over any handshake
//   bus   : slave side of frame_overlap_buffer_if (sample input, frame output, frame_idx)
module frame_overlap_buffer #(
    parameter int DATA_W    = 32,
    parameter int FRAME_LEN = 256,
    parameter int HOP       = 128,
    parameter int IDX_W     = 16
) (
    input logic                    hclk,
    input logic                    rst_n,
    input logic                    flush,
    frame_overlap_buffer_if.slave  bus
);
    localparam int AW = $clog2(FRAME_LEN);
    typedef enum logic [1:0] {FILL, EMIT, REFILL} state_t;
    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_mem [FRAME_LEN];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW-1:0]     r_cnt;
    logic [AW-1:0]     r_out_cnt;
    logic [IDX_W-1:0]  r_frame_idx;
    logic              r_ready;
    logic              r_valid;
    logic              w_acc;
    logic              w_xfer;
    logic              w_last;
    logic              w_close;
    assign w_acc   = bus.valid_in && r_ready && !flush;
    assign w_xfer  = r_valid && bus.ready_in && !flush;
    assign w_last  = r_valid && (r_out_cnt == AW'(FRAME_LEN - 1));
    // closing accept: FRAME_LEN-th sample in FILL, HOP-th sample in REFILL
    assign w_close = w_acc && (r_cnt == (r_state == FILL ? AW'(FRAME_LEN - 1) : AW'(HOP - 1)));
    always_comb begin
        w_next = r_state;
        if (flush)
            w_next = FILL;
        else if (r_state != EMIT && w_close)
            w_next = EMIT;
        else if (r_state == EMIT && w_xfer && w_last)
            w_next = REFILL;
    end
    always_ff @(posedge hclk or negedge rst_n) begin
        if (!rst_n)
            r_state <= FILL;
        else
            r_state <= w_next;
    end
    always_ff @(posedge hclk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready     <= 1'b0;
            r_valid     <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cnt       <= '0;
            r_out_cnt   <= '0;
            r_frame_idx <= '0;
        end else begin
            r_ready <= (w_next != EMIT);
            r_valid <= (w_next == EMIT);
            if (flush) begin
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_cnt       <= '0;
                r_out_cnt   <= '0;
                r_frame_idx <= '0;
            end else begin
                if (w_acc) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    r_cnt    <= r_cnt + 1'b1;
                end
                // buffer is full after the closing write, so the slot after it is the oldest
                if (w_close)
                    r_rd_ptr <= r_wr_ptr + 1'b1;
                if (w_xfer) begin
                    r_rd_ptr  <= r_rd_ptr + 1'b1;
                    r_out_cnt <= r_out_cnt + 1'b1;
                end
                if (w_xfer && w_last) begin
                    r_cnt       <= '0;
                    r_frame_idx <= r_frame_idx + 1'b1;
                end
            end
        end
    end
    always_ff @(posedge hclk) begin
        if (w_acc)
            r_mem[r_wr_ptr] <= bus.data_in;
    end
    assign bus.ready_out = r_ready;
    assign bus.valid_out = r_valid;
    assign bus.last      = w_last;
    assign bus.data_out  = r_mem[r_rd_ptr];
    assign bus.frame_idx = r_frame_idx;
endmodule

// File: tb/tb_frame_overlap_buffer.sv
// tb_frame_overlap_buffer: directed self-checking bench for frame_overlap_buffer (8/4 and 256/256)
module tb_frame_overlap_buffer;
    logic hclk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic big_flush = 1'b0;
    int n_chk = 0;
    int n_err = 0;
    int s, base, frame, pos, acc;
    int fed, got, nb;
    always #5 hclk = ~hclk;
    frame_overlap_buffer_if #(.DATA_W(32), .IDX_W(16)) b ();
    frame_overlap_buffer_if #(.DATA_W(32), .IDX_W(16)) bb ();
    frame_overlap_buffer #(.DATA_W(32), .FRAME_LEN(8), .HOP(4), .IDX_W(16)) u_dut (
        .hclk(hclk), .rst_n(rst_n), .flush(flush), .bus(b)
    );
    frame_overlap_buffer #(.DATA_W(32), .FRAME_LEN(256), .HOP(256), .IDX_W(16)) u_big (
        .hclk(hclk), .rst_n(rst_n), .flush(big_flush), .bus(bb)
    );
    task automatic chk(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        n_chk++;
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
        end
    endtask
    function automatic logic [31:0] pat(input int i);
        return 32'h3f800000 ^ (32'(i) * 32'h9e3779b9);
    endfunction
    // model: frame k word j carries sample base + k*4 + j; acc counts accepts since fill start
    task automatic tick();
        if (flush) begin
            base = s; frame = 0; pos = 0; acc = 0;
        end else begin
            chk("overlap", 64'(b.ready_out && b.valid_out), 64'(0));
            if (b.valid_in && b.ready_out) begin
                acc++;
                s++;
            end
            if (b.valid_out && b.ready_in) begin
                if (pos == 0)
                    chk("accepts", 64'(acc), 64'(8 + 4 * frame));
                chk("data", 64'(b.data_out), 64'(base + frame * 4 + pos));
                chk("last", 64'(b.last), 64'(pos == 7));
                chk("idx", 64'(b.frame_idx), 64'(16'(frame)));
                if (pos == 7) begin
                    pos = 0;
                    frame++;
                end else
                    pos++;
            end
        end
        @(posedge hclk);
        #1;
        b.data_in = 32'(s);
    endtask
    task automatic run_frames(input int target);
        int n = 0;
        while (frame < target && n < 2000) begin
            tick();
            n++;
        end
        chk("frames", 64'(frame), 64'(target));
    endtask
    task automatic run_to_pos(input int p);
        int n = 0;
        while (!(b.valid_out && pos == p) && n < 2000) begin
            tick();
            n++;
        end
        chk("reach", 64'(b.valid_out), 64'(1));
    endtask
    task automatic model_reset();
        base = s; frame = 0; pos = 0; acc = 0;
    endtask
    initial begin
        b.valid_in = 1'b0; b.data_in = '0; b.ready_in = 1'b1;
        bb.valid_in = 1'b0; bb.data_in = '0; bb.ready_in = 1'b1;
        s = 0;
        model_reset();
        #12;
        chk("rst_rdy", 64'(b.ready_out), 64'(0));
        chk("rst_vld", 64'(b.valid_out), 64'(0));
        chk("rst_last", 64'(b.last), 64'(0));
        chk("rst_idx", 64'(b.frame_idx), 64'(0));
        rst_n = 1'b1;
        @(posedge hclk);
        #1;
        chk("rdy_after_rst", 64'(b.ready_out), 64'(1));
        b.valid_in = 1'b1;
        b.data_in = 32'(s);
        run_frames(3);
        run_to_pos(3);
        b.ready_in = 1'b0;
        repeat (100) begin
            tick();
            chk("bp_data", 64'(b.data_out), 64'(base + frame * 4 + 3));
            chk("bp_vld", 64'(b.valid_out), 64'(1));
            chk("bp_last", 64'(b.last), 64'(0));
        end
        b.ready_in = 1'b1;
        run_frames(4);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_rdy", 64'(b.ready_out), 64'(1));
        chk("fl_vld", 64'(b.valid_out), 64'(0));
        chk("fl_idx", 64'(b.frame_idx), 64'(0));
        for (int n = 0; acc < 4 && n < 100; n++)
            tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl5_rdy", 64'(b.ready_out), 64'(1));
        chk("fl5_idx", 64'(b.frame_idx), 64'(0));
        run_frames(1);
        run_to_pos(2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flemit_vld", 64'(b.valid_out), 64'(0));
        chk("flemit_rdy", 64'(b.ready_out), 64'(1));
        chk("flemit_idx", 64'(b.frame_idx), 64'(0));
        run_frames(1);
        run_to_pos(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rsm_vld", 64'(b.valid_out), 64'(0));
        chk("rsm_last", 64'(b.last), 64'(0));
        chk("rsm_rdy", 64'(b.ready_out), 64'(0));
        chk("rsm_idx", 64'(b.frame_idx), 64'(0));
        model_reset();
        #2;
        rst_n = 1'b1;
        @(posedge hclk);
        #1;
        chk("rsm_rdy_up", 64'(b.ready_out), 64'(1));
        run_frames(2);
        b.valid_in = 1'b0;
        fed = 0; got = 0; nb = 0;
        bb.valid_in = 1'b1;
        bb.data_in = pat(0);
        while (got < 256 && nb < 3000) begin
            if (bb.valid_in && bb.ready_out)
                fed++;
            if (bb.valid_out && bb.ready_in) begin
                chk("big_data", 64'(bb.data_out), 64'(pat(got)));
                chk("big_last", 64'(bb.last), 64'(got == 255));
                got++;
            end
            @(posedge hclk);
            #1;
            bb.valid_in = (fed < 256);
            bb.data_in = pat(fed);
            nb++;
        end
        chk("big_words", 64'(got), 64'(256));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
